// File: rtl/key_debounce_if.sv
// Signal bundle between the raw key pins and the debounced key outputs.
// The slave modport is the debouncer; the master modport is the pin/PIO side.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                key_any;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_any
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_any
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer and four-state debounce FSM producing a clean level,
// press/release strobes and a registered any-key flag.
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_ARM_PRESS,
    ST_PRESSED,
    ST_ARM_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level of a released key; also the synchronizer reset value.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] w_level_next;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic                r_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      state_t           r_state;
      state_t           w_state_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             w_s;
      logic             w_press_next;
      logic             w_release_next;
      logic             r_level;
      logic             r_press;
      logic             r_release;

      assign w_s = r_sync2 ^ REL_LVL;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync1   <= REL_LVL;
          r_sync2   <= REL_LVL;
          r_state   <= ST_RELEASED;
          r_cnt     <= '0;
          r_level   <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_sync1   <= bus.key_raw[gi];
          r_sync2   <= r_sync1;
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_level   <= w_level_next[gi];
          r_press   <= w_press_next;
          r_release <= w_release_next;
        end
      end

      always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_s) begin
              w_state_next = ST_ARM_PRESS;
              w_cnt_next   = '0;
            end
          end
          ST_ARM_PRESS: begin
            if (!w_s) begin
              w_state_next = ST_RELEASED;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next = ST_PRESSED;
              w_press_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!w_s) begin
              w_state_next = ST_ARM_RELEASE;
              w_cnt_next   = '0;
            end
          end
          ST_ARM_RELEASE: begin
            if (w_s) begin
              w_state_next = ST_PRESSED;
            end else if (r_cnt == CNT_LAST) begin
              w_state_next   = ST_RELEASED;
              w_release_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_next = ST_RELEASED;
            w_cnt_next   = '0;
          end
        endcase
      end

      // Level comes from the next state so it moves on the same edge as the strobe.
      assign w_level_next[gi] = (w_state_next == ST_PRESSED) ||
                                (w_state_next == ST_ARM_RELEASE);
      assign w_level[gi]      = r_level;
      assign w_press[gi]      = r_press;
      assign w_release[gi]    = r_release;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_level_next;
    end
  end

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;
  assign bus.key_any     = r_any;

endmodule

// File: tb/tb_key_debounce.sv
// Random and directed stimulus for key_debounce, checked against a
// run-length model of the debounce rules.
module tb_key_debounce;
  localparam int NK = 4;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  key_debounce_if #(.NUM_KEYS(NK)) bus ();

  key_debounce #(
    .NUM_KEYS(NK), .CNT_W(20), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Model: pin delayed two edges; a key commits after D+1 consecutive
  // samples that disagree with its debounced level.
  logic [3:0] m_d1, m_d2, m_level, m_press, m_rel;
  int         m_run [NK];

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 4'hF; m_d2 = 4'hF; m_level = '0; m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] s;
    s = ~m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    m_press = '0;
    m_rel = '0;
    for (int k = 0; k < NK; k++) begin
      if (s[k] != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == D + 1) begin
          m_level[k] = s[k];
          m_run[k] = 0;
          if (s[k]) m_press[k] = 1'b1;
          else      m_rel[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] raw);
    bus.key_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_val("level", bus.key_level, m_level);
    check_val("press", bus.key_press, m_press);
    check_val("release", bus.key_release, m_rel);
    check_val("any", {3'b0, bus.key_any}, {3'b0, |m_level});
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_level"}, bus.key_level, 4'h0);
    check_val({tag, "_press"}, bus.key_press, 4'h0);
    check_val({tag, "_release"}, bus.key_release, 4'h0);
    check_val({tag, "_any"}, {3'b0, bus.key_any}, 4'h0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #3 reset_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic settle();
    repeat (8) step(4'hF);
  endtask

  initial begin
    logic [3:0] idx;
    logic [3:0] cnt;
    logic [3:0] raw;
    int         noisy;

    bus.key_raw = 4'hF;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    #2 reset_n = 1'b1;
    settle();

    // Clean press on key 0: commit on the seventh sampling edge.
    idx = 4'hF;
    for (int j = 0; j < 12; j++) begin
      step(4'b1110);
      if (bus.key_press[0] && idx == 4'hF) idx = 4'(j);
    end
    check_val("clean_press_lat", idx, 4'd6);
    settle();

    // Bouncing press on key 1.
    idx = 4'hF; cnt = '0;
    for (int j = 0; j < 14; j++) begin
      step((j == 1 || j == 3) ? 4'b1111 : 4'b1101);
      if (bus.key_press[1]) begin cnt++; if (idx == 4'hF) idx = 4'(j); end
    end
    check_val("bounce_press_cnt", cnt, 4'd1);
    check_val("bounce_press_lat", idx, 4'd10);
    settle();

    // Short glitch on key 2 never commits.
    cnt = '0;
    for (int j = 0; j < 13; j++) begin
      step(j < 3 ? 4'b1011 : 4'b1111);
      if (bus.key_press[2] || bus.key_level[2]) cnt++;
    end
    check_val("glitch_activity", cnt, 4'd0);

    // Release with a one-cycle reassert landing on the commit cycle.
    repeat (10) step(4'b1110);
    idx = 4'hF; cnt = '0;
    for (int j = 0; j < 15; j++) begin
      step(j == 4 ? 4'b1110 : 4'b1111);
      if (bus.key_release[0]) begin cnt++; if (idx == 4'hF) idx = 4'(j); end
    end
    check_val("commit_bounce_rel_cnt", cnt, 4'd1);
    check_val("commit_bounce_rel_lat", idx, 4'd11);
    settle();

    // All keys together, then release key 3 only.
    cnt = '0;
    for (int j = 0; j < 10; j++) begin
      step(4'b0000);
      if (bus.key_press == 4'b1111) cnt++;
    end
    check_val("simul_press", cnt, 4'd1);
    cnt = '0;
    for (int j = 0; j < 10; j++) begin
      step(4'b1000);
      if (bus.key_release == 4'b1000) cnt++;
    end
    check_val("key3_release", cnt, 4'd1);
    check_val("any_held", {3'b0, bus.key_any}, 4'd1);
    settle();

    // Reset while key 0 is arming, pin still held; then fresh debounce.
    repeat (5) step(4'b1110);
    mid_reset();
    idx = 4'hF;
    for (int j = 0; j < 12; j++) begin
      step(4'b1110);
      if (bus.key_press[0] && idx == 4'hF) idx = 4'(j);
    end
    check_val("post_reset_lat", idx, 4'(D + 2));
    settle();

    // Random bouncing on all keys with alternating noise levels.
    raw = 4'hF;
    noisy = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) noisy = $urandom_range(0, 1);
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, noisy ? 3 : 11) == 0) raw[k] = ~raw[k];
      end
      step(raw);
      if ($urandom_range(0, 599) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
